// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file and the stages that use it.
// Holds the sweep FSM state encoding and the default geometry.
package regfile_mp_pkg;

  localparam int DEF_ADDR = 5;
  localparam int DEF_SIZE = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_rd_mux.sv
// One combinational read lane of the register file.
// Applies write bypass (port 1 first) and the hardwired zero register.
module regfile_rd_mux #(
  parameter int ADDR    = 5,
  parameter int SIZE    = 32,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic            run_i,
  input  logic [ADDR-1:0] ra_i,
  input  logic [SIZE-1:0] arr_i,
  input  logic            we0_i,
  input  logic [ADDR-1:0] rw0_i,
  input  logic [SIZE-1:0] w0_i,
  input  logic            we1_i,
  input  logic [ADDR-1:0] rw1_i,
  input  logic [SIZE-1:0] w1_i,
  output logic [SIZE-1:0] rd_o
);

  always_comb begin
    rd_o = '0;
    if (run_i) begin
      if ((BYPASS != 0) && we1_i && (rw1_i == ra_i)) begin
        rd_o = w1_i;
      end else if ((BYPASS != 0) && we0_i && (rw0_i == ra_i)) begin
        rd_o = w0_i;
      end else begin
        rd_o = arr_i;
      end
      // Register 0 reads as zero even when a write to it is being bypassed.
      if ((ZERO_R0 != 0) && (ra_i == '0)) begin
        rd_o = '0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read lanes, two prioritised write ports and
// a post-reset initialisation sweep that fills every register before READY.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int ADDR      = DEF_ADDR,
  parameter int SIZE      = DEF_SIZE,
  parameter int NRD       = 2,
  parameter int ZERO_R0   = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                WE0,
  input  logic [ADDR-1:0]     RW0,
  input  logic [SIZE-1:0]     busW0,
  input  logic                WE1,
  input  logic [ADDR-1:0]     RW1,
  input  logic [SIZE-1:0]     busW1,
  input  logic [NRD*ADDR-1:0] RA,
  output logic [NRD*SIZE-1:0] busR,
  output logic                READY
);

  localparam int NUMB = 2 ** ADDR;

  logic [SIZE-1:0] regs_q [NUMB];
  rf_state_e       state_q;
  logic [ADDR:0]   cnt_q;
  logic [ADDR:0]   cnt_d;
  logic            ready_q;
  logic            run;
  logic [SIZE-1:0] init_val;
  logic            we0_eff;
  logic            we1_eff;

  assign run      = (state_q == ST_RUN);
  assign cnt_d    = cnt_q + 1'b1;
  assign init_val = (INIT_MODE != 0) ? SIZE'(cnt_q[ADDR-1:0]) : '0;

  // Port 0 loses to port 1 on an address clash; register 0 may be read-only.
  assign we1_eff = RST_N && run && WE1 && !((ZERO_R0 != 0) && (RW1 == '0));
  assign we0_eff = RST_N && run && WE0 && !((ZERO_R0 != 0) && (RW0 == '0))
                   && !(WE1 && (RW1 == RW0));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_d;
          // The counter MSB rising marks the write of the last register.
          if (cnt_d[ADDR]) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && (state_q == ST_INIT)) begin
      regs_q[cnt_q[ADDR-1:0]] <= init_val;
    end else begin
      if (we0_eff) regs_q[RW0] <= busW0;
      if (we1_eff) regs_q[RW1] <= busW1;
    end
  end

  assign READY = ready_q;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      regfile_rd_mux #(
        .ADDR   (ADDR),
        .SIZE   (SIZE),
        .ZERO_R0(ZERO_R0),
        .BYPASS (BYPASS)
      ) u_rd (
        .run_i (run),
        .ra_i  (RA[gi*ADDR +: ADDR]),
        .arr_i (regs_q[RA[gi*ADDR +: ADDR]]),
        .we0_i (WE0),
        .rw0_i (RW0),
        .w0_i  (busW0),
        .we1_i (WE1),
        .rw1_i (RW1),
        .w1_i  (busW1),
        .rd_o  (busR[gi*SIZE +: SIZE])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init sweep timing, bypass, write priority,
// zero register and reset restart of the sweep.
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        WE0, WE1;
  logic [4:0]  RW0, RW1;
  logic [31:0] busW0, busW1;
  logic [9:0]  RA;
  logic [63:0] busR;
  logic        READY;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_mp dut (
    .CLK(CLK), .RST_N(RST_N),
    .WE0(WE0), .RW0(RW0), .busW0(busW0),
    .WE1(WE1), .RW1(RW1), .busW1(busW1),
    .RA(RA), .busR(busR), .READY(READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we0;
    logic [4:0]  rw0;
    logic [31:0] w0;
    logic        we1;
    logic [4:0]  rw1;
    logic [31:0] w1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WE0 = 0; WE1 = 0; RW0 = 0; RW1 = 0; busW0 = 0; busW1 = 0;
  endtask

  // Counts edges after release until READY is seen; checks lanes stay 0 meanwhile.
  // Optionally pulses WE0 to address 4 at edge count 10.
  task automatic wait_ready(input bit poke, output int n);
    bit lanes_ok;
    lanes_ok = 1;
    n = 0;
    while (!READY && n < 100) begin
      if (busR !== 64'h0) lanes_ok = 0;
      if (poke && n == 10) begin
        WE0 = 1; RW0 = 5'd4; busW0 = 32'h0000AAAA;
      end else begin
        WE0 = 0;
      end
      tick();
      n++;
    end
    WE0 = 0;
    check("init_lanes_zero", {31'd0, lanes_ok}, 32'd1);
  endtask

  initial begin
    int n;
    idle_inputs();
    RST_N = 0;
    RA = {5'd31, 5'd7};
    tick(); tick();
    check("reset_ready", {31'd0, READY}, 32'd0);
    check("reset_lane0", busR[31:0], 32'd0);
    check("reset_lane1", busR[63:32], 32'd0);

    RST_N = 1;
    wait_ready(1'b1, n);
    check("sweep_cycles", n, 32'd32);
    $display("sweep 1 finished after %0d cycles", n);

    vecs[0]  = '{0, 0, 0,            0, 0, 0,            7,  31, 32'd7,        32'd31};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,            4,  0,  32'd4,        32'd0};
    vecs[2]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            5,  6,  32'hDEADBEEF, 32'd6};
    vecs[3]  = '{0, 0, 0,            0, 0, 0,            5,  5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4]  = '{1, 9, 32'h11111111, 1, 9, 32'h22222222, 9,  10, 32'h22222222, 32'd10};
    vecs[5]  = '{0, 0, 0,            0, 0, 0,            9,  9,  32'h22222222, 32'h22222222};
    vecs[6]  = '{0, 0, 0,            1, 0, 32'hFFFFFFFF, 0,  1,  32'd0,        32'd1};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,            0,  2,  32'd0,        32'd2};
    vecs[8]  = '{1, 12, 32'hC,       1, 13, 32'hD,       12, 13, 32'hC,        32'hD};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,            12, 13, 32'hC,        32'hD};
    vecs[10] = '{1, 3, 32'h33,       0, 0, 0,            3,  31, 32'h33,       32'd31};
    vecs[11] = '{0, 0, 0,            0, 0, 0,            3,  0,  32'h33,       32'd0};

    for (int i = 0; i < 12; i++) begin
      WE0 = vecs[i].we0; RW0 = vecs[i].rw0; busW0 = vecs[i].w0;
      WE1 = vecs[i].we1; RW1 = vecs[i].rw1; busW1 = vecs[i].w1;
      RA = {vecs[i].ra1, vecs[i].ra0};
      #1;
      $display("vec %0d: ra0=%0d lane0=%h ra1=%0d lane1=%h", i, vecs[i].ra0, busR[31:0],
               vecs[i].ra1, busR[63:32]);
      check($sformatf("vec%0d_lane0", i), busR[31:0], vecs[i].exp0);
      check($sformatf("vec%0d_lane1", i), busR[63:32], vecs[i].exp1);
      tick();
    end
    idle_inputs();

    // Reset, run part of the sweep, then reset again at cnt=10.
    RST_N = 0;
    tick();
    check("rst2_ready", {31'd0, READY}, 32'd0);
    RST_N = 1;
    for (int i = 0; i < 10; i++) tick();
    check("midsweep_ready", {31'd0, READY}, 32'd0);
    RST_N = 0;
    tick();
    RST_N = 1;
    wait_ready(1'b0, n);
    check("resweep_cycles", n, 32'd32);
    $display("sweep 2 finished after %0d cycles", n);

    RA = {5'd9, 5'd3};
    #1;
    check("resweep_r3", busR[31:0], 32'd3);
    check("resweep_r9", busR[63:32], 32'd9);
    RA = {5'd5, 5'd4};
    #1;
    check("resweep_r4", busR[31:0], 32'd4);
    check("resweep_r5", busR[63:32], 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
